// File: rtl/pipe_spawn_scheduler.sv
// Pipe obstacle scheduler: scrolls NUM_PIPES slots once per frame, retires off-screen
// pipes, pulses score on bird crossings and periodically spawns a pipe of random height.
module pipe_spawn_scheduler #(
  parameter int NUM_PIPES    = 3,
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 60,
  parameter int SPEED        = 2,
  parameter int SPAWN_FRAMES = 90,
  parameter int BIRD_X       = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   run,
  input  logic                   frame_tick,
  output logic                   rng_en,
  input  logic [15:0]            rng_value,
  output logic [NUM_PIPES-1:0]   pipe_valid,
  output logic [NUM_PIPES*11-1:0] pipe_x,
  output logic [NUM_PIPES*16-1:0] pipe_h,
  output logic                   score_pulse,
  output logic                   busy,
  output logic [1:0]             state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;
  localparam logic [1:0] LOAD = 2'd3;

  localparam int             CW       = $clog2(SPAWN_FRAMES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SPAWN_FRAMES - 1);
  localparam logic [10:0]    SPEED_X  = 11'(SPEED);
  localparam logic [10:0]    BIRD_LO  = 11'(BIRD_X);
  localparam logic [11:0]    BIRD_HI  = 12'(BIRD_X + SPEED);
  localparam logic [10:0]    LOAD_X   = 11'(SCREEN_W + PIPE_W);

  logic [1:0]           state_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_PIPES-1:0] valid_q;
  logic [10:0]          x_q [NUM_PIPES];
  logic [15:0]          h_q [NUM_PIPES];
  logic                 score_q;

  logic [NUM_PIPES-1:0] mv_valid;
  logic [10:0]          mv_x [NUM_PIPES];
  logic                 cross_any;
  logic [NUM_PIPES-1:0] ld_onehot;

  // A crossing is old x above the bird and old x - SPEED at or below it; this
  // form also covers a slot that retires on the same move.
  always_comb begin
    mv_valid  = valid_q;
    cross_any = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      mv_x[i] = x_q[i];
      if (valid_q[i]) begin
        if (x_q[i] <= SPEED_X) mv_valid[i] = 1'b0;
        else                   mv_x[i]     = x_q[i] - SPEED_X;
        if ((x_q[i] > BIRD_LO) && ({1'b0, x_q[i]} <= BIRD_HI)) cross_any = 1'b1;
      end
    end
  end

  // Lowest-index free slot as a one-hot mask.
  assign ld_onehot = ~valid_q & (valid_q + NUM_PIPES'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      score_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      score_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_tick && run) state_q <= MOVE;
        MOVE: begin
          valid_q <= mv_valid;
          for (int i = 0; i < NUM_PIPES; i++) x_q[i] <= mv_x[i];
          score_q <= cross_any;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= (&mv_valid) ? IDLE : REQ;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= IDLE;
          end
        end
        REQ:  state_q <= LOAD;
        default: begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (ld_onehot[i]) begin
              valid_q[i] <= 1'b1;
              x_q[i]     <= LOAD_X;
              h_q[i]     <= rng_value;
            end
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rng_en      = (state_q == REQ);
  assign busy        = (state_q != IDLE);
  assign score_pulse = score_q;
  assign pipe_valid  = valid_q;
  assign state       = state_q;

  always_comb begin
    pipe_x = '0;
    pipe_h = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x[11*i +: 11] = x_q[i];
      pipe_h[16*i +: 16] = h_q[i];
    end
  end

endmodule
